tlb_cp0_unit: RTL and testbench

Fully-associative joint TLB that sits on the far side of the CP0 TLB register interface. It executes TLBR/TLBWI/TLBWR/TLBP commands using CP0 EntryHi/EntryLo0/EntryLo1/Index/Random. Results return through the CP0 write-enable strobes (EntryHi_Wren, EntryLo0_Wren, EntryLo1_Wren, Index_Wren, s1_found). It also serves one registered address-translation lookup port for the fetch/memory stages.

---
 rtl/tlb_cp0_unit_if.sv | 33 +++
 rtl/tlb_cp0_unit.sv | 190 +++++++++++++++++++
 tb/tb_tlb_cp0_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_cp0_unit_if.sv
// CP0 <-> TLB command bus: command handshake, CP0 register snapshots and
// the write-back strobes/data that return to CP0.
interface tlb_cp0_unit_if;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic        cmd_ready;
  logic [31:0] EntryHi_i;
  logic [31:0] EntryLo0_i;
  logic [31:0] EntryLo1_i;
  logic [31:0] Index_i;
  logic [31:0] Random_i;
  logic        EntryHi_Wren;
  logic        EntryLo0_Wren;
  logic        EntryLo1_Wren;
  logic        Index_Wren;
  logic        s1_found;
  logic [31:0] EntryHi_out;
  logic [31:0] EntryLo0_out;
  logic [31:0] EntryLo1_out;
  logic [31:0] Index_out;

  modport master (
    output cmd_valid, cmd_op, EntryHi_i, EntryLo0_i, EntryLo1_i, Index_i, Random_i,
    input  cmd_ready, EntryHi_Wren, EntryLo0_Wren, EntryLo1_Wren, Index_Wren, s1_found,
    input  EntryHi_out, EntryLo0_out, EntryLo1_out, Index_out
  );

  modport slave (
    input  cmd_valid, cmd_op, EntryHi_i, EntryLo0_i, EntryLo1_i, Index_i, Random_i,
    output cmd_ready, EntryHi_Wren, EntryLo0_Wren, EntryLo1_Wren, Index_Wren, s1_found,
    output EntryHi_out, EntryLo0_out, EntryLo1_out, Index_out
  );
endinterface

// File: rtl/tlb_cp0_unit.sv
// Fully-associative joint TLB serving CP0 TLBR/TLBWI/TLBWR/TLBP commands
// plus one registered address-translation lookup port.
module tlb_cp0_unit #(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  tlb_cp0_unit_if.slave      cp0,
  input  logic               lk_req,
  input  logic [31:0]        lk_vaddr,
  input  logic [7:0]         lk_asid,
  output logic               lk_found,
  output logic [19:0]        lk_pfn,
  output logic [2:0]         lk_c,
  output logic               lk_d,
  output logic               lk_v
);

  typedef enum logic [1:0] {IDLE, READ, PROBE, RESP} state_t;

  localparam logic [1:0] OP_TLBR  = 2'd0;
  localparam logic [1:0] OP_TLBWI = 2'd1;
  localparam logic [1:0] OP_TLBWR = 2'd2;
  localparam logic [1:0] OP_TLBP  = 2'd3;

  state_t state, state_next;

  logic [18:0] vpn2 [TLBNUM];
  logic [7:0]  asid [TLBNUM];
  logic        g    [TLBNUM];
  logic [19:0] pfn0 [TLBNUM];
  logic [2:0]  c0   [TLBNUM];
  logic        d0   [TLBNUM];
  logic        v0   [TLBNUM];
  logic [19:0] pfn1 [TLBNUM];
  logic [2:0]  c1   [TLBNUM];
  logic        d1   [TLBNUM];
  logic        v1   [TLBNUM];

  logic              accept, do_write;
  logic [IDX_W-1:0]  wr_idx, cmd_idx;
  logic [TLBNUM-1:0] probe_match, probe_hit, lk_match;
  logic [IDX_W:0]    probe_enc, lk_enc;
  logic              resp_probe, probe_found;
  logic              unused_bits;

  // Returns {found, index} of the lowest set bit.
  function automatic logic [IDX_W:0] lowest(input logic [TLBNUM-1:0] vec);
    lowest = '0;
    for (int i = TLBNUM - 1; i >= 0; i--)
      if (vec[i]) lowest = {1'b1, IDX_W'(i)};
  endfunction

  assign cp0.cmd_ready = (state == IDLE);
  assign accept   = cp0.cmd_valid & cp0.cmd_ready;
  assign do_write = accept & ((cp0.cmd_op == OP_TLBWI) | (cp0.cmd_op == OP_TLBWR));
  assign wr_idx   = (cp0.cmd_op == OP_TLBWR) ? cp0.Random_i[IDX_W-1:0] : cp0.Index_i[IDX_W-1:0];

  assign unused_bits = ^{cp0.Index_i[31:IDX_W], cp0.Random_i[31:IDX_W], cp0.EntryHi_i[12:8],
                         cp0.EntryLo0_i[31:26], cp0.EntryLo1_i[31:26], lk_vaddr[11:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < TLBNUM; i++) begin
        vpn2[i] <= '0;
        asid[i] <= '0;
        g[i]    <= 1'b0;
        pfn0[i] <= '0;
        c0[i]   <= '0;
        d0[i]   <= 1'b0;
        v0[i]   <= 1'b0;
        pfn1[i] <= '0;
        c1[i]   <= '0;
        d1[i]   <= 1'b0;
        v1[i]   <= 1'b0;
      end
    end else if (do_write) begin
      vpn2[wr_idx] <= cp0.EntryHi_i[31:13];
      asid[wr_idx] <= cp0.EntryHi_i[7:0];
      g[wr_idx]    <= cp0.EntryLo0_i[0] & cp0.EntryLo1_i[0];
      pfn0[wr_idx] <= cp0.EntryLo0_i[25:6];
      c0[wr_idx]   <= cp0.EntryLo0_i[5:3];
      d0[wr_idx]   <= cp0.EntryLo0_i[2];
      v0[wr_idx]   <= cp0.EntryLo0_i[1];
      pfn1[wr_idx] <= cp0.EntryLo1_i[25:6];
      c1[wr_idx]   <= cp0.EntryLo1_i[5:3];
      d1[wr_idx]   <= cp0.EntryLo1_i[2];
      v1[wr_idx]   <= cp0.EntryLo1_i[1];
    end
  end

  // Global entries ignore the ASID comparison.
  always_comb begin
    probe_match = '0;
    lk_match    = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      probe_match[i] = (vpn2[i] == cp0.EntryHi_i[31:13]) & (g[i] | (asid[i] == cp0.EntryHi_i[7:0]));
      lk_match[i]    = (vpn2[i] == lk_vaddr[31:13]) & (g[i] | (asid[i] == lk_asid));
    end
  end

  assign probe_enc = lowest(probe_hit);
  assign lk_enc    = lowest(lk_match);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && cp0.cmd_op == OP_TLBR)      state_next = READ;
        else if (accept && cp0.cmd_op == OP_TLBP) state_next = PROBE;
      end
      READ:    state_next = RESP;
      PROBE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cmd_idx          <= '0;
      probe_hit        <= '0;
      resp_probe       <= 1'b0;
      probe_found      <= 1'b0;
      cp0.EntryHi_out  <= '0;
      cp0.EntryLo0_out <= '0;
      cp0.EntryLo1_out <= '0;
      cp0.Index_out    <= '0;
    end else begin
      if (accept) begin
        cmd_idx    <= cp0.Index_i[IDX_W-1:0];
        probe_hit  <= probe_match;
        resp_probe <= (cp0.cmd_op == OP_TLBP);
      end
      if (state == READ) begin
        cp0.EntryHi_out  <= {vpn2[cmd_idx], 5'b0, asid[cmd_idx]};
        cp0.EntryLo0_out <= {6'b0, pfn0[cmd_idx], c0[cmd_idx], d0[cmd_idx], v0[cmd_idx], g[cmd_idx]};
        cp0.EntryLo1_out <= {6'b0, pfn1[cmd_idx], c1[cmd_idx], d1[cmd_idx], v1[cmd_idx], g[cmd_idx]};
      end
      if (state == PROBE) begin
        probe_found   <= probe_enc[IDX_W];
        cp0.Index_out <= probe_enc[IDX_W] ? {{(32-IDX_W){1'b0}}, probe_enc[IDX_W-1:0]} : 32'h8000_0000;
      end
    end
  end

  assign cp0.EntryHi_Wren  = (state == RESP) & ~resp_probe;
  assign cp0.EntryLo0_Wren = (state == RESP) & ~resp_probe;
  assign cp0.EntryLo1_Wren = (state == RESP) & ~resp_probe;
  assign cp0.Index_Wren    = (state == RESP) & resp_probe;
  assign cp0.s1_found      = (state == RESP) & resp_probe & probe_found;

  // Lookup samples the array before any same-edge write lands.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lk_found <= 1'b0;
      lk_pfn   <= '0;
      lk_c     <= '0;
      lk_d     <= 1'b0;
      lk_v     <= 1'b0;
    end else if (lk_req) begin
      lk_found <= lk_enc[IDX_W];
      if (!lk_enc[IDX_W]) begin
        lk_pfn <= '0;
        lk_c   <= '0;
        lk_d   <= 1'b0;
        lk_v   <= 1'b0;
      end else if (lk_vaddr[12]) begin
        lk_pfn <= pfn1[lk_enc[IDX_W-1:0]];
        lk_c   <= c1[lk_enc[IDX_W-1:0]];
        lk_d   <= d1[lk_enc[IDX_W-1:0]];
        lk_v   <= v1[lk_enc[IDX_W-1:0]];
      end else begin
        lk_pfn <= pfn0[lk_enc[IDX_W-1:0]];
        lk_c   <= c0[lk_enc[IDX_W-1:0]];
        lk_d   <= d0[lk_enc[IDX_W-1:0]];
        lk_v   <= v0[lk_enc[IDX_W-1:0]];
      end
    end else begin
      lk_found <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tlb_cp0_unit.sv
// Self-checking bench for tlb_cp0_unit: directed scenarios followed by
// randomized commands/lookups checked against a CP0-register-level model.
module tb_tlb_cp0_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        lk_req;
  logic [31:0] lk_vaddr;
  logic [7:0]  lk_asid;
  logic        lk_found;
  logic [19:0] lk_pfn;
  logic [2:0]  lk_c;
  logic        lk_d;
  logic        lk_v;

  tlb_cp0_unit_if cp0 ();

  tlb_cp0_unit #(.TLBNUM(16), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .cp0(cp0),
    .lk_req(lk_req), .lk_vaddr(lk_vaddr), .lk_asid(lk_asid),
    .lk_found(lk_found), .lk_pfn(lk_pfn), .lk_c(lk_c), .lk_d(lk_d), .lk_v(lk_v)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Model keeps each entry as the words a TLBR would hand back to CP0.
  logic [31:0] mHi  [16];
  logic [31:0] mLo0 [16];
  logic [31:0] mLo1 [16];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] strobes();
    return {27'b0, cp0.EntryHi_Wren, cp0.EntryLo0_Wren, cp0.EntryLo1_Wren, cp0.Index_Wren, cp0.s1_found};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin
      mHi[i] = 0; mLo0[i] = 0; mLo1[i] = 0;
    end
  endtask

  task automatic modelWrite(input int idx, input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1);
    logic gbit;
    gbit = lo0[0] & lo1[0];
    mHi[idx]  = hi & 32'hFFFF_E0FF;
    mLo0[idx] = (lo0 & 32'h03FF_FFFE) | {31'b0, gbit};
    mLo1[idx] = (lo1 & 32'h03FF_FFFE) | {31'b0, gbit};
  endtask

  task automatic modelMatch(input logic [31:0] vpnWord, input logic [7:0] asid, output logic found, output int idx);
    found = 1'b0; idx = 0;
    for (int i = 0; i < 16; i++)
      if (!found && (mHi[i] >> 13) == (vpnWord >> 13) && (mLo0[i][0] || mHi[i][7:0] == asid)) begin
        found = 1'b1; idx = i;
      end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] hi, input logic [31:0] lo0,
                               input logic [31:0] lo1, input logic [31:0] idx, input logic [31:0] rnd);
    cp0.cmd_op = op; cp0.EntryHi_i = hi; cp0.EntryLo0_i = lo0; cp0.EntryLo1_i = lo1;
    cp0.Index_i = idx; cp0.Random_i = rnd; cp0.cmd_valid = 1'b1;
  endtask

  task automatic doWrite(input logic [1:0] op, input int idx, input logic [31:0] hi,
                         input logic [31:0] lo0, input logic [31:0] lo1);
    logic [31:0] other;
    other = $urandom;
    @(negedge clk);
    if (op == 2'd2) applyStimulus(op, hi, lo0, lo1, other, 32'(idx));
    else            applyStimulus(op, hi, lo0, lo1, (other & 32'hFFFF_FFF0) | 32'(idx), other);
    @(negedge clk);
    cp0.cmd_valid = 1'b0;
    modelWrite(idx, hi, lo0, lo1);
    checkOutput("write_ready", {31'b0, cp0.cmd_ready}, 32'd1);
    checkOutput("write_strobes", strobes(), 32'd0);
  endtask

  task automatic doRead(input int idx);
    @(negedge clk);
    applyStimulus(2'd0, $urandom, $urandom, $urandom, 32'(idx), $urandom);
    @(negedge clk);
    cp0.cmd_valid = 1'b0;
    checkOutput("read_busy", {31'b0, cp0.cmd_ready}, 32'd0);
    checkOutput("read_early_strobes", strobes(), 32'd0);
    @(negedge clk);
    checkOutput("read_strobes", strobes(), 32'b11100);
    checkOutput("read_hi", cp0.EntryHi_out, mHi[idx]);
    checkOutput("read_lo0", cp0.EntryLo0_out, mLo0[idx]);
    checkOutput("read_lo1", cp0.EntryLo1_out, mLo1[idx]);
    @(negedge clk);
    checkOutput("read_done_strobes", strobes(), 32'd0);
    checkOutput("read_done_ready", {31'b0, cp0.cmd_ready}, 32'd1);
  endtask

  task automatic doProbe(input logic [31:0] hi);
    logic found;
    int   idx;
    modelMatch(hi, hi[7:0], found, idx);
    @(negedge clk);
    applyStimulus(2'd3, hi, $urandom, $urandom, $urandom, $urandom);
    @(negedge clk);
    cp0.cmd_valid = 1'b0;
    checkOutput("probe_early_strobes", strobes(), 32'd0);
    @(negedge clk);
    checkOutput("probe_strobes", strobes(), {30'b0, 1'b1, found});
    checkOutput("probe_index", cp0.Index_out, found ? 32'(idx) : 32'h8000_0000);
    @(negedge clk);
    checkOutput("probe_done_strobes", strobes(), 32'd0);
  endtask

  task automatic checkLookup(input logic [31:0] vaddr, input logic found, input int idx);
    logic [31:0] lo;
    lo = vaddr[12] ? mLo1[idx] : mLo0[idx];
    checkOutput("lk_found", {31'b0, lk_found}, {31'b0, found});
    if (found) begin
      checkOutput("lk_pfn", {12'b0, lk_pfn}, {12'b0, lo[25:6]});
      checkOutput("lk_cdv", {27'b0, lk_c, lk_d, lk_v}, {27'b0, lo[5:1]});
    end
  endtask

  task automatic doLookup(input logic [31:0] vaddr, input logic [7:0] asid);
    logic found;
    int   idx;
    modelMatch(vaddr, asid, found, idx);
    @(negedge clk);
    lk_req = 1'b1; lk_vaddr = vaddr; lk_asid = asid;
    @(negedge clk);
    lk_req = 1'b0;
    checkLookup(vaddr, found, idx);
  endtask

  initial begin
    logic        found;
    int          idx;
    logic [31:0] hi, lo0, lo1, vaddr;
    logic [7:0]  asid;

    rst = 1'b0; lk_req = 1'b0; lk_vaddr = '0; lk_asid = '0;
    cp0.cmd_valid = 1'b0; cp0.cmd_op = '0; cp0.EntryHi_i = '0; cp0.EntryLo0_i = '0;
    cp0.EntryLo1_i = '0; cp0.Index_i = '0; cp0.Random_i = '0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset_ready", {31'b0, cp0.cmd_ready}, 32'd1);
    checkOutput("reset_strobes", strobes(), 32'd0);
    checkOutput("reset_lk_found", {31'b0, lk_found}, 32'd0);
    checkOutput("reset_hi_out", cp0.EntryHi_out, 32'd0);
    checkOutput("reset_index_out", cp0.Index_out, 32'd0);
    rst = 1'b1;

    doRead(5);
    doWrite(2'd1, 3, 32'h0040_20A5, 32'h0000_1017, 32'h0000_201F);
    doRead(3);
    checkOutput("tlbr3_hi_const", cp0.EntryHi_out, 32'h0040_20A5);
    checkOutput("tlbr3_lo0_const", cp0.EntryLo0_out, 32'h0000_1017);
    checkOutput("tlbr3_lo1_const", cp0.EntryLo1_out, 32'h0000_201F);
    doProbe(32'h0040_20FF);
    checkOutput("probe_g_hit_const", cp0.Index_out, 32'd3);
    doWrite(2'd1, 3, 32'h0040_20A5, 32'h0000_1016, 32'h0000_201F);
    doProbe(32'h0040_2011);
    checkOutput("probe_miss_const", cp0.Index_out, 32'h8000_0000);

    doWrite(2'd1, 2, 32'h0040_2022, 32'h0000_2347, 32'h00F1_E05B);
    doWrite(2'd1, 7, 32'h0040_2022, 32'h0000_0C03, 32'h0000_0FC7);
    doLookup(32'h0040_3000, 8'h22);
    checkOutput("lk_multi_pfn_const", {12'b0, lk_pfn}, 32'h0003_C781);
    @(negedge clk);
    checkOutput("lk_drop", {31'b0, lk_found}, 32'd0);

    // Same-edge TLBWR and lookup: old contents first, new entry a cycle later.
    vaddr = 32'h2469_4000;
    @(negedge clk);
    applyStimulus(2'd2, 32'h2469_4022, 32'h00AB_CD56, 32'h0123_4567, 32'd0, 32'd9);
    lk_req = 1'b1; lk_vaddr = vaddr; lk_asid = 8'h22;
    modelMatch(vaddr, 8'h22, found, idx);
    @(negedge clk);
    cp0.cmd_valid = 1'b0;
    checkLookup(vaddr, found, idx);
    modelWrite(9, 32'h2469_4022, 32'h00AB_CD56, 32'h0123_4567);
    modelMatch(vaddr, 8'h22, found, idx);
    @(negedge clk);
    lk_req = 1'b0;
    checkLookup(vaddr, found, idx);
    checkOutput("collision_pfn_const", {12'b0, lk_pfn}, 32'h0002_AF35);

    @(negedge clk);
    applyStimulus(2'd3, 32'h0040_20A5, 32'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    cp0.cmd_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_strobes", strobes(), 32'd0);
    rst = 1'b1;
    modelReset();
    @(negedge clk);
    checkOutput("abort_after_strobes", strobes(), 32'd0);
    checkOutput("abort_ready", {31'b0, cp0.cmd_ready}, 32'd1);

    for (int n = 0; n < 80; n++) begin
      asid = ($urandom_range(0, 1) == 0) ? 8'h11 : 8'h22;
      hi   = {19'h00100 + 19'($urandom_range(0, 3)), 5'($urandom), asid};
      lo0  = $urandom;
      lo1  = $urandom;
      case ($urandom_range(0, 3))
        0: doWrite(2'($urandom_range(1, 2)), $urandom_range(0, 15), hi, lo0, lo1);
        1: doRead($urandom_range(0, 15));
        2: doProbe(hi);
        default: doLookup({hi[31:13], 1'($urandom), 12'($urandom)}, asid);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
